fifo_sync_fwft_flex: RTL

Self-contained synchronous first-word-fall-through FIFO with no external FIFO primitive underneath. It adds an exact occupancy count, programmable full/empty thresholds, a synchronous flush and optional sticky overflow/underflow flags. It is the general-purpose buffering element for single-clock datapaths between protocol front-ends and packet logic.

---
 rtl/fifo_sync_fwft_flex_if.sv | 31 +++
 rtl/fifo_sync_fwft_flex.sv | 98 +++++++++
 2 files changed

// File: rtl/fifo_sync_fwft_flex_if.sv
// Bus bundle for fifo_sync_fwft_flex: write side, read side, flush and status.
// master = producer/consumer side driving the FIFO; slave = the FIFO itself.
interface fifo_sync_fwft_flex_if #(
  parameter int DW    = 32,
  parameter int DEPTH = 16,
  parameter int AW    = $clog2(DEPTH)
);
  logic          flush;
  logic [DW-1:0] din;
  logic          wr_en;
  logic          full;
  logic          prog_full;
  logic [DW-1:0] dout;
  logic          rd_en;
  logic          empty;
  logic          prog_empty;
  logic [AW:0]   count;
  logic          overflow;
  logic          underflow;

  // Handshake: a write transfers on a rising edge when wr_en=1 and full=0;
  // a read transfers when rd_en=1 and empty=0. dout is valid whenever empty=0.
  modport master (
    output flush, din, wr_en, rd_en,
    input  full, prog_full, dout, empty, prog_empty, count, overflow, underflow
  );
  modport slave (
    input  flush, din, wr_en, rd_en,
    output full, prog_full, dout, empty, prog_empty, count, overflow, underflow
  );
endinterface

// File: rtl/fifo_sync_fwft_flex.sv
// Single-clock first-word-fall-through FIFO: (DEPTH-1)-entry array plus output register.
// Define FIFO_FWFT_ERRFLAGS_EN to build sticky overflow/underflow flags.
module fifo_sync_fwft_flex #(
  parameter int DW         = 32,
  parameter int DEPTH      = 16,
  parameter int PROG_FULL  = DEPTH / 2,
  parameter int PROG_EMPTY = 1,
  parameter int AW         = $clog2(DEPTH)
) (
  input logic                 clk,
  input logic                 rst,
  fifo_sync_fwft_flex_if.slave bus
);
  localparam int          MEM_N   = DEPTH - 1;
  localparam logic [AW:0] LP_FULL = (AW+1)'(DEPTH);
  localparam logic [AW:0] LP_PF   = (AW+1)'(PROG_FULL);
  localparam logic [AW:0] LP_PE   = (AW+1)'(PROG_EMPTY);
  localparam logic [AW:0] LP_ONE  = (AW+1)'(1);
  localparam logic [AW-1:0] LP_LAST = AW'(DEPTH - 2);

  logic [DW-1:0] r_mem [MEM_N];
  logic [DW-1:0] r_dout;
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [AW:0]   r_count;

  logic w_full, w_empty, w_arr_nonempty;
  logic w_wr_acc, w_rd_acc, w_pop_arr, w_wr_arr, w_wr_out;

  assign w_full         = (r_count == LP_FULL);
  assign w_empty        = (r_count == '0);
  // The output register holds the head whenever count>0, so the array holds count-1.
  assign w_arr_nonempty = (r_count > LP_ONE);

  assign w_wr_acc  = bus.wr_en && !w_full && !bus.flush;
  assign w_rd_acc  = bus.rd_en && !w_empty && !bus.flush;
  assign w_pop_arr = w_rd_acc && w_arr_nonempty;
  assign w_wr_out  = w_wr_acc && (w_empty || (w_rd_acc && !w_arr_nonempty));
  assign w_wr_arr  = w_wr_acc && !w_wr_out;

  function automatic logic [AW-1:0] next_ptr(input logic [AW-1:0] p);
    return (p == LP_LAST) ? '0 : p + 1'b1;
  endfunction

  always_ff @(posedge clk) begin
    if (w_wr_arr) r_mem[r_wr_ptr] <= bus.din;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_dout   <= '0;
    end else if (bus.flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_wr_arr)  r_wr_ptr <= next_ptr(r_wr_ptr);
      if (w_pop_arr) r_rd_ptr <= next_ptr(r_rd_ptr);
      if (w_pop_arr)     r_dout <= r_mem[r_rd_ptr];
      else if (w_wr_out) r_dout <= bus.din;
      case ({w_wr_acc, w_rd_acc})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

`ifdef FIFO_FWFT_ERRFLAGS_EN
  logic r_overflow, r_underflow;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
    end else if (!bus.flush) begin
      if (bus.wr_en && w_full)  r_overflow  <= 1'b1;
      if (bus.rd_en && w_empty) r_underflow <= 1'b1;
    end
  end

  assign bus.overflow  = r_overflow;
  assign bus.underflow = r_underflow;
`else
  assign bus.overflow  = 1'b0;
  assign bus.underflow = 1'b0;
`endif

  assign bus.dout       = r_dout;
  assign bus.count      = r_count;
  assign bus.full       = w_full;
  assign bus.empty      = w_empty;
  assign bus.prog_full  = (r_count >= LP_PF);
  assign bus.prog_empty = (r_count <= LP_PE);
endmodule
